strhw_ctrl_fsm: RTL and testbench

Parameterised next-generation control FSM for the Streebog (GOST 34.11-2018) core. It sits between the host-side block interface and the stage (compression) block. It accepts message blocks over a valid/ready handshake and pads the final partial block. It sequences the stage through block, N-finalisation and Σ-finalisation operations, keeps the algorithm state (h, N, Σ), and presents the 256- or 512-bit digest through a hold-until-taken output handshake.

---
 rtl/strhw_ctrl_fsm_if.sv | 42 ++++
 rtl/strhw_ctrl_fsm.sv | 225 ++++++++++++++++++++++
 tb/tb_strhw_ctrl_fsm.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/strhw_ctrl_fsm_if.sv
// Host block, digest and stage-operation signals around the Streebog control FSM.
// master = control FSM side, slave = host/stage side.
interface strhw_ctrl_fsm_if #(
  parameter int LEN_W = 7
);
  logic             blk_valid_i;
  logic             blk_ready_o;
  logic [511:0]     blk_i;
  logic [LEN_W-1:0] blk_len_i;
  logic             blk_last_i;
  logic             hash_size_i;
  logic [511:0]     hash_o;
  logic             hash_valid_o;
  logic             hash_ready_i;
  logic [2:0]       state_o;
  logic             err_o;
  logic             st_trg_o;
  logic [1:0]       st_op_o;
  logic [511:0]     st_block_o;
  logic [9:0]       st_nbits_o;
  logic [511:0]     st_h_o;
  logic [511:0]     st_n_o;
  logic [511:0]     st_sigma_o;
  logic             st_done_i;
  logic [511:0]     st_h_new_i;
  logic [511:0]     st_n_new_i;
  logic [511:0]     st_sigma_new_i;

  modport master (
    input  blk_valid_i, blk_i, blk_len_i, blk_last_i, hash_size_i, hash_ready_i,
    input  st_done_i, st_h_new_i, st_n_new_i, st_sigma_new_i,
    output blk_ready_o, hash_o, hash_valid_o, state_o, err_o,
    output st_trg_o, st_op_o, st_block_o, st_nbits_o, st_h_o, st_n_o, st_sigma_o
  );

  modport slave (
    output blk_valid_i, blk_i, blk_len_i, blk_last_i, hash_size_i, hash_ready_i,
    output st_done_i, st_h_new_i, st_n_new_i, st_sigma_new_i,
    input  blk_ready_o, hash_o, hash_valid_o, state_o, err_o,
    input  st_trg_o, st_op_o, st_block_o, st_nbits_o, st_h_o, st_n_o, st_sigma_o
  );
endinterface

// File: rtl/strhw_ctrl_fsm.sv
// Streebog control FSM: pads host blocks, sequences BLOCK/FIN_N/FIN_S stage ops, holds h/N/Sigma.
// 1 cycle overhead per op; blk_ready_o only in READY; digest held until taken. 256-bit mode: STRHW_CTRL_HASH256_EN.
module strhw_ctrl_fsm #(
  parameter int LEN_W       = 7,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  strhw_ctrl_fsm_if.master bus
);

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_READY = 3'd1,
    ST_BUSY  = 3'd2,
    ST_FIN_N = 3'd3,
    ST_FIN_S = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    OP_BLOCK = 2'd0,
    OP_FIN_N = 2'd1,
    OP_FIN_S = 2'd2
  } op_e;

  state_e       state_q, state_d;
  op_e          op_q, op_d;
  logic [511:0] h_q, h_d, n_q, n_d, sig_q, sig_d, blk_q, blk_d;
  logic [9:0]   nbits_q, nbits_d;
  logic         last_q, last_d, full_q, full_d, first_q, first_d;
  logic         mode256_q, mode256_d, trg_q, trg_d, err_q, err_d;
  logic [31:0]  wd_q, wd_d;
  logic         wd_expired;

  logic [31:0]  len_w;
  logic         len_full;
  logic [511:0] pad_blk;
  logic [511:0] iv;

  assign len_w    = 32'(bus.blk_len_i);
  // Lengths above 64 are treated as a full block rather than over-reading the bus.
  assign len_full = (len_w >= 32'd64);

  always_comb begin
    pad_blk = '0;
    for (int k = 0; k < 64; k++) begin
      if (len_full || (32'(k) < len_w)) begin
        pad_blk[8*k +: 8] = bus.blk_i[8*k +: 8];
      end else if (32'(k) == len_w) begin
        pad_blk[8*k +: 8] = 8'h01;
      end
    end
  end

`ifdef STRHW_CTRL_HASH256_EN
  assign iv         = bus.hash_size_i ? {64{8'h01}} : '0;
  assign bus.hash_o = mode256_q ? {256'h0, h_q[511:256]} : h_q;
`else
  logic unused_cfg;
  assign unused_cfg = bus.hash_size_i ^ mode256_q;
  assign iv         = '0;
  assign bus.hash_o = h_q;
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    h_d        = h_q;
    n_d        = n_q;
    sig_d      = sig_q;
    blk_d      = blk_q;
    nbits_d    = nbits_q;
    last_d     = last_q;
    full_d     = full_q;
    first_d    = first_q;
    mode256_d  = mode256_q;
    trg_d      = 1'b0;
    err_d      = err_q;
    wd_d       = wd_q;
    wd_expired = 1'b0;

    if ((TIMEOUT_CYC > 0) && !bus.st_done_i &&
        (state_q == ST_BUSY || state_q == ST_FIN_N || state_q == ST_FIN_S)) begin
      wd_d       = wd_q + 32'd1;
      wd_expired = (wd_d >= 32'(TIMEOUT_CYC));
    end

    case (state_q)
      ST_CLEAR: begin
        n_d     = '0;
        sig_d   = '0;
        first_d = 1'b1;
        state_d = ST_READY;
      end
      ST_READY: begin
        if (bus.blk_valid_i) begin
          if (!len_full && !bus.blk_last_i) begin
            err_d   = 1'b1;
            state_d = ST_ERROR;
          end else begin
            if (first_q) begin
              first_d = 1'b0;
              h_d     = iv;
`ifdef STRHW_CTRL_HASH256_EN
              mode256_d = bus.hash_size_i;
`endif
            end
            blk_d   = pad_blk;
            nbits_d = len_full ? 10'd512 : 10'(len_w << 3);
            last_d  = bus.blk_last_i;
            full_d  = len_full;
            trg_d   = 1'b1;
            op_d    = OP_BLOCK;
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (bus.st_done_i) begin
          h_d   = bus.st_h_new_i;
          n_d   = bus.st_n_new_i;
          sig_d = bus.st_sigma_new_i;
          if (!last_q) begin
            state_d = ST_READY;
          end else if (full_q) begin
            // A full final block still needs its own padding block.
            blk_d   = 512'h1;
            nbits_d = 10'd0;
            full_d  = 1'b0;
            trg_d   = 1'b1;
            op_d    = OP_BLOCK;
          end else begin
            trg_d   = 1'b1;
            op_d    = OP_FIN_N;
            state_d = ST_FIN_N;
          end
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = ST_ERROR;
        end
      end
      ST_FIN_N: begin
        if (bus.st_done_i) begin
          h_d     = bus.st_h_new_i;
          trg_d   = 1'b1;
          op_d    = OP_FIN_S;
          state_d = ST_FIN_S;
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = ST_ERROR;
        end
      end
      ST_FIN_S: begin
        if (bus.st_done_i) begin
          h_d     = bus.st_h_new_i;
          state_d = ST_DONE;
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = ST_ERROR;
        end
      end
      ST_DONE: begin
        if (bus.hash_ready_i) state_d = ST_CLEAR;
      end
      ST_ERROR: begin
        err_d = 1'b1;
      end
      default: begin
        err_d   = 1'b1;
        state_d = ST_ERROR;
      end
    endcase

    if (trg_d) wd_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= ST_CLEAR;
      op_q      <= OP_BLOCK;
      h_q       <= '0;
      n_q       <= '0;
      sig_q     <= '0;
      blk_q     <= '0;
      nbits_q   <= '0;
      last_q    <= 1'b0;
      full_q    <= 1'b0;
      first_q   <= 1'b0;
      mode256_q <= 1'b0;
      trg_q     <= 1'b0;
      err_q     <= 1'b0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      h_q       <= h_d;
      n_q       <= n_d;
      sig_q     <= sig_d;
      blk_q     <= blk_d;
      nbits_q   <= nbits_d;
      last_q    <= last_d;
      full_q    <= full_d;
      first_q   <= first_d;
      mode256_q <= mode256_d;
      trg_q     <= trg_d;
      err_q     <= err_d;
      wd_q      <= wd_d;
    end
  end

  assign bus.blk_ready_o  = (state_q == ST_READY);
  assign bus.hash_valid_o = (state_q == ST_DONE);
  assign bus.state_o      = state_q;
  assign bus.err_o        = err_q;
  assign bus.st_trg_o     = trg_q;
  assign bus.st_op_o      = op_q;
  assign bus.st_block_o   = blk_q;
  assign bus.st_nbits_o   = nbits_q;
  assign bus.st_h_o       = h_q;
  assign bus.st_n_o       = n_q;
  assign bus.st_sigma_o   = sig_q;

endmodule

// File: tb/tb_strhw_ctrl_fsm.sv
// Randomized bench for strhw_ctrl_fsm: toy 4-cycle stage plus a message-level reference model.
`timescale 1ns/1ps
module tb_strhw_ctrl_fsm;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  strhw_ctrl_fsm_if #(.LEN_W(7)) bus ();
  strhw_ctrl_fsm #(.LEN_W(7), .TIMEOUT_CYC(TMO)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [511:0] pad(input logic [511:0] d, input int len);
    logic [511:0] one;
    one = 512'h1;
    if (len >= 64) return d;
    return (d & ((one << (8*len)) - one)) | (one << (8*len));
  endfunction

  // Toy compression: any deterministic mixing is enough to expose misrouted state.
  function automatic void stage_step(input logic [1:0] op, input logic [511:0] blk, input logic [9:0] nb,
                                     input logic [511:0] h, input logic [511:0] n, input logic [511:0] s,
                                     output logic [511:0] ho, output logic [511:0] no, output logic [511:0] so);
    logic [511:0] rh;
    rh = {h[510:0], h[511]};
    no = ~n;
    so = ~s;
    case (op)
      2'd0: begin ho = rh ^ blk ^ n; no = n + 512'(nb); so = s + blk; end
      2'd1: ho = rh ^ n ^ 512'h5;
      default: ho = rh + s;
    endcase
  endfunction

  // Stage model: answers each trigger four cycles later and logs the ops it saw.
  bit stage_en = 1'b1;
  int st_cnt = 0;
  int fins_done_cyc = -1;
  logic [1:0]   cap_op;
  logic [9:0]   cap_nb;
  logic [511:0] cap_blk, cap_h, cap_n, cap_s;
  logic [1:0]   ob_op[$];
  int           ob_nb[$];
  logic [511:0] ob_blk[$];

  initial begin
    logic [511:0] hn, nn, sn;
    bus.st_done_i = 1'b0;
    bus.st_h_new_i = '0;
    bus.st_n_new_i = '0;
    bus.st_sigma_new_i = '0;
    forever begin
      @(negedge clk);
      bus.st_done_i = 1'b0;
      if (bus.st_trg_o === 1'b1) begin
        cap_op = bus.st_op_o; cap_nb = bus.st_nbits_o; cap_blk = bus.st_block_o;
        cap_h = bus.st_h_o; cap_n = bus.st_n_o; cap_s = bus.st_sigma_o;
        ob_op.push_back(cap_op); ob_nb.push_back(int'(cap_nb)); ob_blk.push_back(cap_blk);
        st_cnt = stage_en ? 3 : 0;
      end else if (st_cnt > 0) begin
        st_cnt--;
        if (st_cnt == 0) begin
          if (bus.state_o inside {3'd2, 3'd3, 3'd4}) begin
            chk("operand_h_hold", bus.st_h_o, cap_h);
            chk("operand_blk_hold", bus.st_block_o, cap_blk);
          end
          stage_step(cap_op, cap_blk, cap_nb, cap_h, cap_n, cap_s, hn, nn, sn);
          bus.st_h_new_i = hn; bus.st_n_new_i = nn; bus.st_sigma_new_i = sn;
          bus.st_done_i = 1'b1;
          if (cap_op == 2'd2) fins_done_cyc = cyc + 1;
        end
      end
    end
  end

  // Handshake invariants observed every cycle outside reset.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk("blk_ready_only_in_ready", bus.blk_ready_o, (bus.state_o == 3'd1));
      chk("hash_valid_only_in_done", bus.hash_valid_o, (bus.state_o == 3'd5));
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not reach its end");
    $fatal(1, "global timeout");
  end

  // Reference model: message-level digest and expected op sequence.
  logic [511:0] m_blk[8];
  int           m_len[8];
  int           m_n;
  logic [1:0]   e_op[$];
  int           e_nb[$];
  logic [511:0] e_blk[$];

  task automatic build_model(input bit m256, output logic [511:0] digest);
    logic [511:0] h, n, s, b, hn, nn, sn;
    int nb;
    h = m256 ? {64{8'h01}} : '0;
    n = '0;
    s = '0;
    for (int i = 0; i < m_n; i++) begin
      b  = pad(m_blk[i], m_len[i]);
      nb = (m_len[i] >= 64) ? 512 : 8 * m_len[i];
      e_op.push_back(2'd0); e_nb.push_back(nb); e_blk.push_back(b);
      stage_step(2'd0, b, 10'(nb), h, n, s, hn, nn, sn);
      h = hn; n = nn; s = sn;
    end
    if (m_len[m_n-1] >= 64) begin
      e_op.push_back(2'd0); e_nb.push_back(0); e_blk.push_back(512'h1);
      stage_step(2'd0, 512'h1, 10'd0, h, n, s, hn, nn, sn);
      h = hn; n = nn; s = sn;
    end
    e_op.push_back(2'd1); e_nb.push_back(0); e_blk.push_back('0);
    stage_step(2'd1, '0, 10'd0, h, n, s, hn, nn, sn);
    h = hn;
    e_op.push_back(2'd2); e_nb.push_back(0); e_blk.push_back('0);
    stage_step(2'd2, '0, 10'd0, h, n, s, hn, nn, sn);
    h = hn;
    digest = m256 ? {256'h0, h[511:256]} : h;
  endtask

  task automatic send_block(input logic [511:0] d, input int len, input bit last);
    int budget;
    bit taken;
    budget = 0;
    taken  = 1'b0;
    while (!taken && budget < 200) begin
      @(negedge clk);
      budget++;
      if ($urandom_range(0, 3) == 0) begin
        bus.blk_valid_i = 1'b0;
      end else begin
        bus.blk_valid_i = 1'b1;
        bus.blk_i = d;
        bus.blk_len_i = 7'(len);
        bus.blk_last_i = last;
        if (bus.blk_ready_o === 1'b1) taken = 1'b1;
      end
    end
    if (!taken) chk("accept_timeout", bus.blk_ready_o, 1);
    @(posedge clk);
    #1 bus.blk_valid_i = 1'b0;
  endtask

  task automatic run_msg(input int nblk, input int last_len, input bit hs, input int hold);
    logic [511:0] digest;
    bit eff;
    int budget;
    ob_op.delete(); ob_nb.delete(); ob_blk.delete();
    e_op.delete(); e_nb.delete(); e_blk.delete();
    m_n = nblk;
    for (int i = 0; i < nblk; i++) begin
      m_blk[i] = rand512();
      m_len[i] = (i == nblk - 1) ? last_len : 64;
    end
`ifdef STRHW_CTRL_HASH256_EN
    eff = hs;
`else
    eff = 1'b0;
`endif
    build_model(eff, digest);
    bus.hash_size_i = hs;
    for (int i = 0; i < nblk; i++) send_block(m_blk[i], m_len[i], i == nblk - 1);
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (bus.hash_valid_o !== 1'b1 && budget < 500);
    chk("hash_valid_seen", bus.hash_valid_o, 1);
    chk("valid_1cyc_after_fin_s", cyc, fins_done_cyc);
    chk("digest", bus.hash_o, digest);
    chk("op_count", ob_op.size(), e_op.size());
    for (int i = 0; i < e_op.size() && i < ob_op.size(); i++) begin
      chk("op_kind", ob_op[i], e_op[i]);
      if (e_op[i] == 2'd0) begin
        chk("op_nbits", ob_nb[i], e_nb[i]);
        chk("op_block", ob_blk[i], e_blk[i]);
      end
    end
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("digest_hold_valid", bus.hash_valid_o, 1);
      chk("digest_hold_value", bus.hash_o, digest);
    end
    bus.hash_ready_i = 1'b1;
    @(negedge clk);
    bus.hash_ready_i = 1'b0;
    chk("clear_after_take", bus.state_o, 0);
    @(negedge clk);
    chk("ready_after_clear", bus.state_o, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"}, bus.state_o, 0);
    chk({tag, "_blk_ready"}, bus.blk_ready_o, 0);
    chk({tag, "_hash_valid"}, bus.hash_valid_o, 0);
    chk({tag, "_err"}, bus.err_o, 0);
    chk({tag, "_trg"}, bus.st_trg_o, 0);
    chk({tag, "_op"}, bus.st_op_o, 0);
    chk({tag, "_nbits"}, bus.st_nbits_o, 0);
    chk({tag, "_block"}, bus.st_block_o, 0);
    chk({tag, "_hash"}, bus.hash_o, 0);
    chk({tag, "_h"}, bus.st_h_o, 0);
    chk({tag, "_n"}, bus.st_n_o, 0);
    chk({tag, "_sigma"}, bus.st_sigma_o, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", bus.state_o, 1);
  endtask

  initial begin
    bus.blk_valid_i = 1'b0;
    bus.blk_i = '0;
    bus.blk_len_i = '0;
    bus.blk_last_i = 1'b0;
    bus.hash_size_i = 1'b0;
    bus.hash_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_por", bus.state_o, 1);

    // Directed messages: empty, 63-byte in both modes, full last block, three blocks with slow consumer.
    run_msg(1, 0, 1'b0, 0);
    run_msg(1, 63, 1'b0, 2);
    run_msg(1, 63, 1'b1, 2);
    run_msg(1, 64, 1'b0, 1);
    run_msg(3, $urandom_range(0, 63), 1'(($urandom) & 1), 5);
    for (int r = 0; r < 8; r++) begin
      run_msg($urandom_range(1, 4), $urandom_range(0, 64), 1'(($urandom) & 1), $urandom_range(0, 5));
    end

    // Short non-last block: protocol error, block dropped.
    @(negedge clk);
    bus.blk_valid_i = 1'b1;
    bus.blk_i = rand512();
    bus.blk_len_i = 7'd10;
    bus.blk_last_i = 1'b0;
    @(posedge clk);
    #1 bus.blk_valid_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("err_state", bus.state_o, 6);
      chk("err_flag", bus.err_o, 1);
      chk("err_no_trigger", bus.st_trg_o, 0);
      chk("err_not_ready", bus.blk_ready_o, 0);
    end
    do_reset();

    // Stage never answers: watchdog trips exactly TMO cycles after the trigger.
    stage_en = 1'b0;
    @(negedge clk);
    bus.blk_valid_i = 1'b1;
    bus.blk_i = rand512();
    bus.blk_len_i = 7'd5;
    bus.blk_last_i = 1'b1;
    @(posedge clk);
    #1 bus.blk_valid_i = 1'b0;
    @(negedge clk);
    chk("wd_trigger", bus.st_trg_o, 1);
    repeat (TMO - 1) @(negedge clk);
    chk("wd_still_busy", bus.state_o, 2);
    @(negedge clk);
    chk("wd_error_state", bus.state_o, 6);
    chk("wd_error_flag", bus.err_o, 1);
    stage_en = 1'b1;
    do_reset();

    // Reset in the middle of an op; the late done must be ignored.
    @(negedge clk);
    bus.blk_valid_i = 1'b1;
    bus.blk_i = rand512();
    bus.blk_len_i = 7'd20;
    bus.blk_last_i = 1'b1;
    @(posedge clk);
    #1 bus.blk_valid_i = 1'b0;
    @(negedge clk);
    chk("mid_trigger", bus.st_trg_o, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_busy");
    rst = 1'b1;
    @(negedge clk);
    chk("mid_ready", bus.state_o, 1);
    repeat (3) @(negedge clk);
    chk("late_done_ignored_state", bus.state_o, 1);
    chk("late_done_ignored_h", bus.st_h_o, 0);
    chk("late_done_ignored_n", bus.st_n_o, 0);
    run_msg(2, $urandom_range(0, 64), 1'(($urandom) & 1), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
